fu_issue_fifo: RTL

- Per-functional-unit issue queue. It sits directly downstream of the reservation station's 3-wide issue port and upstream of one functional unit.
- Each instance filters the three issue packets by FU class and enqueues the matching ones in priority order.
- It presents one packet per cycle to its FU over a valid/ready handshake.
- It drives that FU class's bit of FU_FIFO_PACKET, which the RS uses to suppress issue when fewer than 3 slots are free.

---
 rtl/fu_issue_fifo_pkg.sv | 35 +++
 rtl/fu_enq_compact.sv | 36 +++
 rtl/fu_issue_fifo.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fu_issue_fifo_pkg.sv
// Shared types for the per-FU issue queues: FU class select, RS issue
// packet, per-class stall vector, queue sizing defaults and a popcount helper.
package fu_issue_fifo_pkg;

    localparam int FU_FIFO_DEPTH   = 8;
    localparam int FU_STALL_MARGIN = 3;

    typedef enum logic [1:0] {
        ALU_1  = 2'd0,
        LS_1   = 2'd1,
        MULT_1 = 2'd2,
        BRANCH = 2'd3
    } FU_SELECT;

    typedef struct packed {
        logic        valid;
        FU_SELECT    dec_fu_unit_sel;
        logic [31:0] pc;
        logic [7:0]  dest_tag;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } RS_S_PACKET;

    typedef struct packed {
        logic branch;
        logic mult;
        logic ls;
        logic alu;
    } FU_FIFO_PACKET;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/fu_enq_compact.sv
// Enqueue compactor: turns three per-slot match bits into write enables and
// consecutive write indices starting at tail (slot 2 first), truncated to the
// free capacity so the lowest-priority matches are the ones dropped.
module fu_enq_compact
    import fu_issue_fifo_pkg::*;
#(
    parameter int AW = 3,
    parameter int CW = 4
) (
    input  logic [2:0]          i_match,
    input  logic [AW-1:0]       i_tail,
    input  logic [CW-1:0]       i_cap,
    output logic [2:0]          o_we,
    output logic [2:0][AW-1:0]  o_widx,
    output logic [1:0]          o_num_enq
);

    logic [1:0]      w_cap3;
    logic [2:0][1:0] w_rank;

    // Rank each slot by the number of higher-priority matches, then gate by capacity
    always_comb begin
        w_cap3    = (i_cap >= CW'(3)) ? 2'd3 : i_cap[1:0];
        w_rank[2] = 2'd0;
        w_rank[1] = 2'(i_match[2]);
        w_rank[0] = 2'(i_match[2]) + 2'(i_match[1]);
        o_we      = '0;
        o_widx    = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            o_we[k]   = i_match[k] && (w_rank[k] < w_cap3);
            o_widx[k] = i_tail + AW'(w_rank[k]);
        end
        o_num_enq = popcnt3(o_we);
    end

endmodule

// File: rtl/fu_issue_fifo.sv
// Per-functional-unit issue queue: filters the 3-wide RS issue by FU class,
// enqueues matches in slot order 2,1,0 and hands one packet per cycle to the
// FU over valid/ready. fifo_stall is derived from the registered count only.
// Optional feature: FU_FIFO_BYPASS_EN adds a zero-latency empty-queue bypass.
module fu_issue_fifo
    import fu_issue_fifo_pkg::*;
#(
    parameter FU_SELECT FU_TYPE      = ALU_1,
    parameter int       DEPTH        = FU_FIFO_DEPTH,
    parameter int       STALL_MARGIN = FU_STALL_MARGIN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  RS_S_PACKET [2:0]         issue_pkts,
    input  logic                     squash,
    input  logic                     fu_ready,
    output RS_S_PACKET               fu_pkt,
    output logic                     fifo_stall,
    output logic [$clog2(DEPTH):0]   free_cnt,
    output logic                     overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    RS_S_PACKET          r_mem [DEPTH];
    logic [AW-1:0]       r_head;
    logic [AW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic                r_ovf;

    logic [2:0]          w_match;
    logic [2:0]          w_match_eff;
    logic                w_pop;
    logic [CW-1:0]       w_cap;
    logic [CW-1:0]       w_free;
    logic [2:0]          w_we;
    logic [2:0][AW-1:0]  w_widx;
    logic [1:0]          w_num_enq;
    logic                w_drop;
`ifdef FU_FIFO_BYPASS_EN
    logic [2:0]          w_hi;
    logic                w_byp_valid;
    logic                w_byp_take;
    RS_S_PACKET          w_byp_pkt;
`endif

    // Match filtering, pop, capacity (pop frees a slot first) and bypass selection
    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            w_match[k] = issue_pkts[k].valid && (issue_pkts[k].dec_fu_unit_sel == FU_TYPE);
        end
        w_pop       = (r_count != '0) && fu_ready;
        w_cap       = CW'(DEPTH) - r_count + CW'(w_pop);
        w_free      = CW'(DEPTH) - r_count;
        w_match_eff = w_match;
`ifdef FU_FIFO_BYPASS_EN
        w_hi        = w_match[2] ? 3'b100 : (w_match[1] ? 3'b010 : (w_match[0] ? 3'b001 : 3'b000));
        w_byp_valid = (r_count == '0) && !squash && (w_match != '0);
        w_byp_take  = w_byp_valid && fu_ready;
        w_byp_pkt   = w_match[2] ? issue_pkts[2] : (w_match[1] ? issue_pkts[1] : issue_pkts[0]);
        if (w_byp_take) begin
            w_match_eff = w_match & ~w_hi;
        end
`endif
    end

    fu_enq_compact #(
        .AW (AW),
        .CW (CW)
    ) u_compact (
        .i_match   (w_match_eff),
        .i_tail    (r_tail),
        .i_cap     (w_cap),
        .o_we      (w_we),
        .o_widx    (w_widx),
        .o_num_enq (w_num_enq)
    );

    assign w_drop = (w_match_eff & ~w_we) != '0;

    // Output head packet, free count and registered stall
    always_comb begin
        fu_pkt = '0;
        if (r_count != '0) begin
            fu_pkt       = r_mem[r_head];
            fu_pkt.valid = 1'b1;
        end
`ifdef FU_FIFO_BYPASS_EN
        else if (w_byp_valid) begin
            fu_pkt = w_byp_pkt;
        end
`endif
        free_cnt     = w_free;
        fifo_stall   = w_free < CW'(STALL_MARGIN);
        overflow_err = r_ovf;
    end

    // Buffer state: reset beats squash, squash beats enqueue/dequeue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (w_we[k]) begin
                    r_mem[w_widx[k]] <= issue_pkts[k];
                end
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_tail  <= r_tail + AW'(w_num_enq);
            r_count <= r_count + CW'(w_num_enq) - CW'(w_pop);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule
